// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: IDLE -> RUN -> DONE, with PC, branch counter and table lookup.
// Optional PC-relative branches are enabled by defining FETCH_SEQ_REL_BRANCH_EN.
module fetch_seq #(
  parameter int PC_width = 10,
  parameter int PC_START = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                halt,
  input  logic                stall,
  input  logic                branch_en,
  input  logic [3:0]          branch_idx,
  input  logic                rel_mode,
  output logic [3:0]          lut_addr,
  input  logic [PC_width-1:0] lut_data,
  output logic [PC_width-1:0] pc,
  output logic                busy,
  output logic                done,
  output logic [7:0]          branch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PC_width-1:0] PC_INIT = PC_width'(PC_START);

  state_t              state_r;
  logic [PC_width-1:0] target_s;

  // The target table is combinational, so its index follows branch_idx directly.
  assign lut_addr = branch_idx;

`ifdef FETCH_SEQ_REL_BRANCH_EN
  // Branch target: relative adds the signed table value to pc, wrapping naturally.
  always_comb begin
    target_s = lut_data;
    if (rel_mode) begin
      target_s = pc + lut_data;
    end else begin
      target_s = lut_data;
    end
  end
`else
  logic unused_rel_s;
  assign unused_rel_s = rel_mode;

  // Branch target: all branches are absolute in this build.
  always_comb begin
    target_s = lut_data;
  end
`endif

  // Sequencer state, program counter, branch counter and registered status flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      pc         <= PC_INIT;
      busy       <= 1'b0;
      done       <= 1'b0;
      branch_cnt <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= RUN;
            pc         <= PC_INIT;
            branch_cnt <= 8'd0;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (halt) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (stall) begin
            busy <= 1'b1;
          end else if (branch_en) begin
            pc <= target_s;
            if (branch_cnt != 8'd255) begin
              branch_cnt <= branch_cnt + 8'd1;
            end
          end else begin
            pc <= pc + PC_width'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter PC_width, default 10, width of program counter and branch-target bus.
REQ-002 Parameter PC_START, default 0, PC value loaded on reset and on each start.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; forces reset state immediately, independent of Clk.
REQ-005 start  input  1  request to begin program execution; sampled only in IDLE.
REQ-006 halt  input  1  decoded halt instruction; ends execution.
REQ-007 stall  input  1  freeze PC and counters for this cycle.
REQ-008 branch_en  input  1  decoded branch taken this cycle.
REQ-009 branch_idx  input  4  target-table index for the branch.
REQ-010 rel_mode  input  1  branch is PC-relative; used only when REL_BRANCH_EN is defined.
REQ-011 lut_addr  output  4  index driven to the combinational target table.
REQ-012 lut_data  input  PC_width  target value returned by the table in the same cycle.
REQ-013 pc  output  PC_width  current program counter, registered.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  single-cycle pulse when execution completes.
REQ-016 branch_cnt  output  8  count of taken branches in the current run.

Function
REQ-017 States SHALL be IDLE, RUN, DONE; encoding is free; there are no other reachable states.
REQ-018 lut_addr SHALL equal branch_idx combinationally in every state (zero-latency table access).
REQ-019 IDLE: pc held, busy=0, done=0; start=1 -> RUN next cycle with pc<=PC_START, branch_cnt<=0.
REQ-020 RUN: busy=1; per-cycle priority SHALL be halt > stall > branch_en > increment.
REQ-021 RUN, halt=1: pc held, -> DONE next cycle, regardless of stall/branch_en.
REQ-022 RUN, stall=1 (halt=0): pc, branch_cnt, state held; branch_en ignored.
REQ-023 RUN, branch_en=1 (absolute): pc<=lut_data next cycle; branch_cnt increments.
REQ-024 RUN, no event: pc<=pc+1 modulo 2^PC_width (all-ones wraps to 0, no flag).
REQ-025 branch_cnt SHALL saturate at 255; further taken branches leave it at 255.
REQ-026 start asserted in RUN or DONE SHALL be ignored (no restart, no pc reload).
REQ-027 DONE: done=1 for exactly one cycle, busy=0, pc and branch_cnt held, -> IDLE unconditionally.
REQ-028 pc and branch_cnt SHALL remain readable in IDLE until next start.

Reset
REQ-029 Reset=1 SHALL force state=IDLE, pc=PC_START, busy=0, done=0, branch_cnt=0 asynchronously.
REQ-030 Reset asserted mid-RUN SHALL abort the run with no done pulse; release returns to IDLE behaviour on the next edge.
REQ-031 No input is sampled while Reset=1.

Configuration
REQ-032 Macro FETCH_SEQ_REL_BRANCH_EN: when defined, branch_en=1 with rel_mode=1 SHALL set pc<=pc+lut_data (lut_data as two's-complement, modulo 2^PC_width); rel_mode=0 remains absolute.
REQ-033 When FETCH_SEQ_REL_BRANCH_EN is undefined, rel_mode port SHALL exist but be ignored; all branches absolute.
REQ-034 branch_cnt counts relative and absolute taken branches identically.

Verification
REQ-035 Reset, start=1 one cycle, 4 idle cycles -> pc 0,1,2,3,4; busy=1; branch_cnt=0.
REQ-036 RUN at pc=0x008, branch_en=1, branch_idx=5, lut_data=0x016 -> lut_addr=5 same cycle; pc=0x016 next; branch_cnt=1.
REQ-037 RUN, halt=1 with stall=1 and branch_en=1 same cycle -> pc unchanged, DONE next, done high exactly 1 cycle, then IDLE, busy=0.
REQ-038 RUN at pc=0x3FF, no events -> pc=0x000; 300 taken branches -> branch_cnt=255.
REQ-039 With FETCH_SEQ_REL_BRANCH_EN: pc=0x008, rel_mode=1, lut_data=0x3FC -> pc=0x004; without macro same stimulus -> pc=0x3FC.
REQ-040 Reset pulsed mid-RUN at pc=0x022 between edges -> pc=PC_START, busy=0 immediately, no done pulse.
